// File: rtl/dm_store_buffer.sv
// ---------------------------------------------------------------------------
// dm_store_buffer
//   Data-memory port for the MEM stage. Stores are parked in a 2-entry FIFO
//   in front of a single-port word RAM. One entry is written back (drained)
//   per cycle whenever the RAM port is not needed by a load. Loads see the
//   RAM word merged byte-wise with the pending stores, so the buffering is
//   invisible to software.
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous, active-high reset
//   st_valid  in   1  store request this cycle
//   st_addr   in  32  store byte address (word index = st_addr[ADDR_HI:2])
//   st_wdata  in  32  lane-aligned store data
//   st_be     in   4  byte enables, bit i writes st_wdata[8i+7:8i]
//   ld_valid  in   1  load request this cycle
//   ld_addr   in  32  load byte address (word granular)
//   ld_data   out 32  merged load word, combinational
//   stall     out  1  pipeline freeze, current request not accepted
//   empty     out  1  no pending stores
// ---------------------------------------------------------------------------
module dm_store_buffer #(
  parameter int DM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_be,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        empty
);

  localparam int AW      = $clog2(DM_WORDS);
  localparam int ADDR_HI = AW + 1;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic [3:0]    be;
  } entry_t;

  entry_t      r_fifo [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_mem [DM_WORDS];

  logic          w_full;
  logic          w_drain;
  logic          w_accept;
  logic [AW-1:0] w_st_idx;
  logic [AW-1:0] w_ld_idx;
  entry_t        w_old;
  entry_t        w_new;
  logic          w_old_vld;
  logic          w_new_vld;
  logic [1:0]    w_count_nxt;
  logic [31:0]   w_ram_word;

  // Address bits outside the word index are deliberately ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{st_addr[31:ADDR_HI+1], st_addr[1:0],
                           ld_addr[31:ADDR_HI+1], ld_addr[1:0]};

  assign w_st_idx = st_addr[ADDR_HI:2];
  assign w_ld_idx = ld_addr[ADDR_HI:2];

  // Port arbitration: a full buffer always drains and blocks every request;
  // otherwise a load owns the port and the drain waits.
  assign w_full   = (r_count == 2'd2);
  assign stall    = w_full && (st_valid || ld_valid);
  assign w_drain  = w_full || (!ld_valid && (r_count != 2'd0));
  // A store presented together with a load is dropped; the load wins.
  assign w_accept = st_valid && !ld_valid && !stall && (st_be != 4'd0);
  assign empty    = (r_count == 2'd0);

  assign w_count_nxt = r_count + {1'b0, w_accept} - {1'b0, w_drain};

  // Oldest entry sits at rd_ptr; the newer one (only live at count==2) is
  // the other slot, so wrap-around is just the inverted pointer.
  assign w_old     = r_fifo[r_rd_ptr];
  assign w_new     = r_fifo[~r_rd_ptr];
  assign w_old_vld = (r_count != 2'd0);
  assign w_new_vld = w_full;

  assign w_ram_word = r_mem[w_ld_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ld_data = w_ram_word;
    for (int b = 0; b < 4; b++) begin
      if (w_new_vld && (w_new.idx == w_ld_idx) && w_new.be[b])
        ld_data[8*b +: 8] = w_new.data[8*b +: 8];
      else if (w_old_vld && (w_old.idx == w_ld_idx) && w_old.be[b])
        ld_data[8*b +: 8] = w_old.data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= '{idx: w_st_idx, data: st_wdata, be: st_be};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_drain)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: the RAM array has no reset; its contents survive reset and only
  // the buffer control state is cleared.
  always_ff @(posedge clk) begin
    if (w_drain) begin
      for (int b = 0; b < 4; b++) begin
        if (w_old.be[b])
          r_mem[w_old.idx][8*b +: 8] <= w_old.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_dm_store_buffer
//   Directed scenarios plus randomized traffic against a queue-based model
//   of the store buffer: pending stores are a plain queue, RAM is an array,
//   a load is the RAM word with every matching pending store applied from
//   oldest to newest.
// ---------------------------------------------------------------------------
module tb_dm_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        stall;
  logic        empty;

  dm_store_buffer #(.DM_WORDS(2048)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .stall    (stall),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_illegal = 0;

  // Reference model state.
  bit [31:0] mem_m [2048];
  int        q_idx [$];
  bit [31:0] q_dat [$];
  bit [3:0]  q_be  [$];
  logic [31:0] last_ld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(a[12:2]);
  endfunction

  function automatic bit [31:0] model_load(input int idx);
    bit [31:0] w;
    w = mem_m[idx];
    foreach (q_idx[i])
      if (q_idx[i] == idx)
        for (int b = 0; b < 4; b++)
          if (q_be[i][b]) w[8*b +: 8] = q_dat[i][8*b +: 8];
    return w;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance model at the
  // rising edge.
  task automatic step(input logic st, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [3:0] be, input logic ld, input logic [31:0] la);
    bit exp_stall, drain, accept;
    st_valid = st; st_addr = sa; st_wdata = sd; st_be = be;
    ld_valid = ld; ld_addr = la;
    if (st && ld) n_illegal++;
    @(negedge clk);
    exp_stall = (q_idx.size() == 2) && (st || ld);
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    check("empty", {31'd0, empty}, {31'd0, q_idx.size() == 0});
    if (ld && !exp_stall) check("ld_data", ld_data, model_load(word_of(la)));
    last_ld = ld_data;
    @(posedge clk);
    drain  = (q_idx.size() == 2) || (!ld && q_idx.size() > 0);
    accept = st && !ld && !exp_stall && (be != 4'd0);
    if (drain) begin
      for (int b = 0; b < 4; b++)
        if (q_be[0][b]) mem_m[q_idx[0]][8*b +: 8] = q_dat[0][8*b +: 8];
      void'(q_idx.pop_front()); void'(q_dat.pop_front()); void'(q_be.pop_front());
    end
    if (accept) begin
      q_idx.push_back(word_of(sa)); q_dat.push_back(sd); q_be.push_back(be);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, a, d, be, 1'b0, 32'd0);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, a);
  endtask

  // Random address within words 0..15, with junk in the ignored bits.
  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_E000) | ($urandom_range(0, 15) << 2) | ($urandom & 32'h3);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0;
    #12;
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Give words 0..15 known contents.
    for (int w = 0; w < 16; w++) store(w << 2, $urandom, 4'hF);
    idle(); idle();

    // Full word store, drained after one idle cycle, then read back.
    store(32'h10, 32'h1234_5678, 4'hF);
    idle();
    idle();
    check("t1_empty", {31'd0, empty}, 32'd1);
    load(32'h10);
    check("t1_lw", last_ld, 32'h1234_5678);
    load(32'h8000_2013);
    check("t1_alias", last_ld, 32'h1234_5678);

    // Byte store forwarded to an immediately following load.
    store(32'h20, 32'h1122_3344, 4'hF);
    idle(); idle();
    store(32'h20, 32'h00AB_0000, 4'b0100);
    load(32'h20);
    check("t2_fwd", last_ld, 32'h11AB_3344);
    check("t2_nostall", {31'd0, stall}, 32'd0);

    // Back-to-back stores to one word: order and merge.
    store(32'h30, 32'h0, 4'hF);
    idle(); idle();
    store(32'h30, 32'hBEEF_0000, 4'b1100);
    store(32'h30, 32'h0000_00CC, 4'b0001);
    load(32'h30);
    check("t3_merge", last_ld, 32'hBEEF_00CC);

    // Loads every cycle hold off the drain; dropping them lets it through.
    store(32'h34, 32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 4; i++) begin
      load(32'h34);
      check("t5_ld", last_ld, 32'hCAFE_F00D);
      check("t5_pending", {31'd0, empty}, 32'd0);
    end
    idle();
    check("t5_empty", {31'd0, empty}, 32'd1);

    // Zero byte-enable store is a no-op.
    store(32'h34, 32'hFFFF_FFFF, 4'd0);
    check("be0_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset with a store pending discards it.
    store(32'h38, 32'h5555_AAAA, 4'hF);
    idle(); idle();
    store(32'h38, 32'hDEAD_BEEF, 4'hF);
    st_valid = 1'b1; st_addr = 32'h3C; st_wdata = 32'h0; st_be = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    q_idx.delete(); q_dat.delete(); q_be.delete();
    st_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    load(32'h38);
    check("rst_ram_kept", last_ld, 32'h5555_AAAA);

    // Randomized traffic, including occasional illegal store+load pairs.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      step(1'b1, rand_addr(), $urandom, 4'($urandom), 1'b0, 32'd0);
      else if (r < 85) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, rand_addr());
      else if (r < 90) step(1'b1, rand_addr(), $urandom, 4'($urandom), 1'b1, rand_addr());
      else             idle();
    end
    idle(); idle();
    for (int w = 0; w < 16; w++) load(w << 2);

    if (n_illegal > 0) $display("note: %0d illegal store+load cycles (store dropped)", n_illegal);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
